mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined core. It serialises one outstanding transaction at a time, with data requests given priority over fetch. It returns responses to the owning requester and raises per-stage stall signals that the pipeline control logic combines with the load-use stall. Branch/jump flushes cancel in-flight fetches, and the stale response is discarded.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles a transaction may stay outstanding; range 2..65535
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- if_req  in  1  fetch request; level, held with if_addr stable until if_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetch data; meaningful only while if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; level, held with dm_we/dm_be/dm_addr/dm_wdata stable until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  DW/8  byte enables
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data; meaningful only while dm_valid and load
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- flush  in  1  pipeline redirect; cancels any fetch, pending or in flight
- mem_req, mem_we, mem_be, mem_addr, mem_wdata  out  1/1/DW/8/AW/DW  memory request channel
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response/write-ack; never earlier than the cycle after mem_gnt
- mem_rdata  in  DW  response data
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  dm_req & ~dm_valid
- timeout_err  out  1  sticky watchdog error

## Operation
- States:
  - IDLE: no transaction.
  - REQ: mem_req=1, awaiting mem_gnt.
  - WAIT: granted, awaiting mem_rvalid.
  - DROP: cancelled fetch granted, awaiting mem_rvalid to discard.
- Owner register (I/D) latched on leaving IDLE. mem_we/be/addr/wdata are muxed from the owner's inputs (dm_* when D; when I, mem_we=0, mem_be=all-ones, mem_wdata=0).
- IDLE:
  - dm_req → owner=D, REQ.
  - Else if_req & ~flush → owner=I, REQ.
  - Else stay. No preemption after leaving IDLE.
- REQ:
  - mem_gnt → WAIT.
  - Owner I with flush & ~mem_gnt → IDLE; request withdrawn.
  - Owner I with flush & mem_gnt → DROP.
- WAIT:
  - mem_rvalid → pulse owner's valid, rdata = mem_rdata, go IDLE.
  - Owner I with flush and no mem_rvalid → DROP.
  - Owner I with flush and mem_rvalid in the same cycle → no if_valid, go IDLE.
- DROP: mem_rvalid → IDLE; no valid pulse.
- mem_rvalid in IDLE or REQ is ignored.
- Valid outputs are combinational from mem_rvalid & state & owner; rdata outputs pass mem_rdata through.
- Watchdog:
  - Counter clears on leaving IDLE and increments each cycle in REQ/WAIT/DROP.
  - On reaching TIMEOUT: set timeout_err, go IDLE, no valid pulse.
  - timeout_err clears only on reset.

## Timing
- Reset values: state IDLE, owner I, counter 0, timeout_err 0; mem_req, if_valid, dm_valid all 0. Stall outputs follow their equations.
- Request latency: request seen in IDLE at cycle n → mem_req at n+1.
- Completion: valid pulse in the same cycle as mem_rvalid; state is IDLE at the next edge.
- Minimum occupancy: 3 cycles per access (REQ, WAIT, IDLE). Back-to-back requests from the same or the other requester are re-arbitrated in IDLE.
- Both requesters asserting in IDLE: D wins; I stays stalled.
- Reset mid-transaction: the transaction is abandoned. A late mem_rvalid arriving after reset release is ignored (state is IDLE).

## Structure
- Package otter_mem_pkg holds:
  - arb_state_t enum {IDLE, REQ, WAIT, DROP}
  - arb_owner_t enum {OWN_I, OWN_D}
  - default AW/DW constants
- Sub-module mem_arb_watchdog: counter plus sticky error. Inputs clk, reset, clear, run; outputs expired, err.
- Remaining logic (FSM, owner mux, valid routing) lives in mem_port_arbiter.

## Test plan
- Fetch only: if_addr=0x100, memory gnt same cycle, rvalid 2 cycles later with 0x00500093 → if_valid pulse one cycle with if_rdata=0x00500093; stall_if high until that cycle.
- Simultaneous: dm_req store 0xDEADBEEF to 0x2000 with if_req to 0x104 → mem_addr=0x2000, mem_we=1 first; dm_valid; then fetch 0x104 issued; if_valid after.
- Flush before grant: fetch 0x108, mem_gnt held 0 for 3 cycles, flush in cycle 2 → mem_req drops next cycle, no if_valid.
- Flush after grant: fetch granted, flush in WAIT, rvalid 3 cycles later → no if_valid; a following dm_req is issued only after that rvalid.
- Timeout: TIMEOUT=8, mem_gnt never asserted → timeout_err=1 after 8 cycles in REQ; state IDLE; err stays 1 until reset.
- Reset mid-WAIT: assert reset with a load outstanding, release, then stray mem_rvalid → no dm_valid; all outputs at reset values.

Source files
------------

// File: rtl/otter_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otter_mem_pkg
// Description : Shared types and default widths for the unified memory-port
//               arbiter. Holds the arbiter state and owner enumerations and
//               the default address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package otter_mem_pkg;

  localparam int unsigned C_DEF_AW = 32;
  localparam int unsigned C_DEF_DW = 32;

  // Watchdog counter width; wide enough for the largest allowed TIMEOUT.
  localparam int unsigned C_WD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no transaction
    REQ  = 2'd1,  // mem_req high, waiting for mem_gnt
    WAIT = 2'd2,  // granted, waiting for mem_rvalid
    DROP = 2'd3   // cancelled fetch granted, swallowing its response
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,  // instruction fetch
    OWN_D = 1'b1   // data memory
  } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_watchdog
// Description : Transaction watchdog for the memory-port arbiter. Counts the
//               cycles a transaction stays outstanding and flags expiry in the
//               TIMEOUT-th cycle; the error flag is sticky until reset.
// Ports       : clk     - clock
//               reset   - asynchronous active-low reset
//               clear   - restart the count (transaction starting)
//               run     - a transaction is outstanding this cycle
//               expired - this is the TIMEOUT-th outstanding cycle
//               err     - sticky timeout error
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog
  import otter_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired,
  output logic err
);

  localparam logic [C_WD_W-1:0] C_LAST = C_WD_W'(TIMEOUT - 1);

  logic [C_WD_W-1:0] r_cnt;
  logic              r_err;

  // The count is 0 in the first outstanding cycle, so the TIMEOUT-th cycle
  // sees TIMEOUT-1; the arbiter leaves on that edge.
  assign expired = run & (r_cnt == C_LAST);
  assign err     = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (clear) begin
        r_cnt <= '0;
      end else if (run) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (expired) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch (IF) and
//               data memory (MEM). One outstanding transaction at a time,
//               data requests win over fetch, flush cancels fetches and the
//               stale response is swallowed. Includes a sticky watchdog.
// Ports       : clk, reset (async active-low)
//               if_req/if_addr -> if_rdata/if_valid      fetch side
//               dm_req/we/be/addr/wdata -> dm_rdata/dm_valid  data side
//               flush                                    pipeline redirect
//               mem_req/we/be/addr/wdata, mem_gnt,
//               mem_rvalid/mem_rdata                     memory channel
//               stall_if, stall_mem                      per-stage stalls
//               timeout_err                              sticky watchdog error
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import otter_mem_pkg::*;
#(
  parameter int unsigned AW      = C_DEF_AW,
  parameter int unsigned DW      = C_DEF_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_valid,
  input  logic            flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            timeout_err
);

  arb_state_t r_state;
  arb_owner_t r_owner;

  logic w_start;
  logic w_owner_i;
  logic w_cancel;
  logic w_expired;
  logic w_wd_clear;
  logic w_wd_run;
  logic w_resp;

  // A fetch is only started when no flush is redirecting it this cycle.
  assign w_start   = dm_req | (if_req & ~flush);
  assign w_owner_i = (r_owner == OWN_I);
  // Flush only affects transactions owned by the fetch side.
  assign w_cancel  = w_owner_i & flush;

  assign w_wd_clear = (r_state == IDLE) & w_start;
  assign w_wd_run   = (r_state != IDLE);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_wd_clear),
    .run     (w_wd_run),
    .expired (w_expired),
    .err     (timeout_err)
  );

  // Responses count only in WAIT; a watchdog expiry in the same cycle wins.
  assign w_resp   = (r_state == WAIT) & mem_rvalid & ~w_expired;
  assign if_valid = w_resp & w_owner_i & ~flush;
  assign dm_valid = w_resp & ~w_owner_i;
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  // Request channel follows the latched owner; fetches are full-word reads.
  assign mem_req   = (r_state == REQ);
  assign mem_we    = w_owner_i ? 1'b0              : dm_we;
  assign mem_be    = w_owner_i ? {(DW/8){1'b1}}    : dm_be;
  assign mem_addr  = w_owner_i ? if_addr           : dm_addr;
  assign mem_wdata = w_owner_i ? {DW{1'b0}}        : dm_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_owner <= OWN_I;
    end else begin
      case (r_state)
        IDLE: begin
          if (dm_req) begin
            r_owner <= OWN_D;
            r_state <= REQ;
          end else if (if_req & ~flush) begin
            r_owner <= OWN_I;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_expired) begin
            r_state <= IDLE;
          end else if (mem_gnt) begin
            // Granted while being flushed: the response must still be eaten.
            r_state <= w_cancel ? DROP : WAIT;
          end else if (w_cancel) begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (w_expired | mem_rvalid) begin
            r_state <= IDLE;
          end else if (w_cancel) begin
            r_state <= DROP;
          end
        end
        DROP: begin
          if (w_expired | mem_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               reference model predicts every output each cycle; directed
//               scenarios are followed by randomized requesters and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_valid;
  logic            dm_req;
  logic            dm_we;
  logic [DW/8-1:0] dm_be;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW-1:0]   dm_rdata;
  logic            dm_valid;
  logic            flush;
  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            stall_if;
  logic            stall_mem;
  logic            timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: one transaction record (who owns it, granted yet,
  // cancelled by flush, how long outstanding) plus the sticky error.
  bit m_busy, m_is_d, m_granted, m_cancel, m_err;
  int m_age;

  bit          prev_if_valid, prev_dm_valid;
  logic [31:0] last_gnt_addr;
  int          n_fetch_done, n_data_done;

  task automatic model_reset();
    m_busy = 0; m_is_d = 0; m_granted = 0; m_cancel = 0; m_err = 0; m_age = 0;
  endtask

  task automatic model_start(input bit is_d);
    m_busy = 1; m_is_d = is_d; m_granted = 0; m_cancel = 0; m_age = 0;
  endtask

  // Called at a negedge after inputs are driven: checks this cycle's outputs,
  // advances the model across the coming rising edge, returns at next negedge.
  task automatic step();
    bit expire, e_req, e_if, e_dm;
    #1;
    expire = m_busy && (m_age == TO - 1);
    e_req  = m_busy && !m_granted;
    e_if   = m_busy && m_granted && !m_cancel && !m_is_d && mem_rvalid && !flush && !expire;
    e_dm   = m_busy && m_granted && !m_cancel &&  m_is_d && mem_rvalid && !expire;
    check_eq("mem_req", mem_req, e_req);
    check_eq("if_valid", if_valid, e_if);
    check_eq("dm_valid", dm_valid, e_dm);
    check_eq("stall_if", stall_if, if_req && !e_if);
    check_eq("stall_mem", stall_mem, dm_req && !e_dm);
    check_eq("timeout_err", timeout_err, m_err);
    if (e_req) begin
      check_eq("mem_we",    mem_we,    m_is_d ? dm_we    : 1'b0);
      check_eq("mem_be",    mem_be,    m_is_d ? dm_be    : 4'hF);
      check_eq("mem_addr",  mem_addr,  m_is_d ? dm_addr  : if_addr);
      check_eq("mem_wdata", mem_wdata, m_is_d ? dm_wdata : 32'h0);
    end
    if (e_if) check_eq("if_rdata_pass", if_rdata, mem_rdata);
    if (e_dm && !dm_we) check_eq("dm_rdata_pass", dm_rdata, mem_rdata);
    if (mem_req && mem_gnt) last_gnt_addr = mem_addr;
    prev_if_valid = if_valid;
    prev_dm_valid = dm_valid;
    n_fetch_done += int'(e_if);
    n_data_done  += int'(e_dm);
    if (reset) begin
      if (!m_busy) begin
        if (dm_req) model_start(1);
        else if (if_req && !flush) model_start(0);
      end else begin
        m_age++;
        if (expire) begin
          m_busy = 0; m_err = 1;
        end else if (!m_granted) begin
          if (mem_gnt) begin
            m_granted = 1;
            if (!m_is_d && flush) m_cancel = 1;
          end else if (!m_is_d && flush) begin
            m_busy = 0;
          end
        end else if (mem_rvalid) begin
          m_busy = 0;
        end else if (!m_is_d && flush) begin
          m_cancel = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0;
    dm_wdata = '0; flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    model_reset();
    repeat (2) step();
    reset = 1;
    step();
  endtask

  bit resp_pending;
  int resp_wait, gnt_wait;

  initial begin
    reset = 0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_dm_valid", dm_valid, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    do_reset();

    // Fetch only: grant on first REQ cycle, response two cycles later.
    if_req = 1; if_addr = 32'h100; step();
    mem_gnt = 1; #1 check_eq("t1_addr", mem_addr, 32'h100); step();
    mem_gnt = 0; #1 check_eq("t1_stall_wait", stall_if, 1); step();
    mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    #1 check_eq("t1_if_valid", if_valid, 1);
    check_eq("t1_if_rdata", if_rdata, 32'h0050_0093);
    check_eq("t1_stall_done", stall_if, 0);
    step();
    mem_rvalid = 0; if_req = 0; step();

    // Simultaneous: data store wins, then fetch.
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h104; step();
    #1 check_eq("t2_first_addr", mem_addr, 32'h2000);
    check_eq("t2_first_we", mem_we, 1);
    mem_gnt = 1; step();
    mem_gnt = 0; mem_rvalid = 1; #1 check_eq("t2_dm_valid", dm_valid, 1); step();
    mem_rvalid = 0; dm_req = 0; dm_we = 0; step();
    #1 check_eq("t2_second_addr", mem_addr, 32'h104);
    check_eq("t2_second_we", mem_we, 0);
    mem_gnt = 1; step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    #1 check_eq("t2_if_valid", if_valid, 1); step();
    mem_rvalid = 0; if_req = 0; step();

    // Flush before grant: request withdrawn, no fetch completion.
    if_req = 1; if_addr = 32'h108; step();
    step();
    flush = 1; step();
    flush = 0; if_req = 0; #1 check_eq("t3_req_dropped", mem_req, 0); step();
    step();

    // Flush after grant: response swallowed, data request waits for it.
    if_req = 1; if_addr = 32'h10C; step();
    mem_gnt = 1; step();
    mem_gnt = 0; flush = 1; step();
    flush = 0; if_req = 0; dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h3000;
    #1 check_eq("t4_dm_blocked", mem_req, 0); step();
    step();
    mem_rvalid = 1; mem_rdata = 32'hBAD0_0001;
    #1 check_eq("t4_no_if_valid", if_valid, 0);
    check_eq("t4_no_dm_valid", dm_valid, 0);
    step();
    mem_rvalid = 0; step();
    #1 check_eq("t4_dm_addr", mem_addr, 32'h3000);
    mem_gnt = 1; step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
    #1 check_eq("t4_dm_valid", dm_valid, 1);
    check_eq("t4_dm_rdata", dm_rdata, 32'hCAFE_0001);
    step();
    mem_rvalid = 0; dm_req = 0; step();

    // Timeout: grant never arrives.
    dm_req = 1; dm_we = 0; dm_addr = 32'h4000; step();
    for (int k = 0; k < TO; k++) begin
      #1 check_eq("t5_req_held", mem_req, 1);
      check_eq("t5_err_low", timeout_err, 0);
      step();
    end
    dm_req = 0;
    #1 check_eq("t5_err_set", timeout_err, 1);
    check_eq("t5_idle", mem_req, 0);
    repeat (3) step();
    check_eq("t5_err_sticky", timeout_err, 1);

    // Reset mid-WAIT with a load outstanding, then a stray response.
    dm_req = 1; dm_we = 0; dm_addr = 32'h5000; step();
    mem_gnt = 1; step();
    mem_gnt = 0; step();
    reset = 0; dm_req = 0;
    #1 check_eq("t6_rst_err", timeout_err, 0);
    check_eq("t6_rst_req", mem_req, 0);
    model_reset();
    step();
    reset = 1; step();
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    #1 check_eq("t6_stray_dm", dm_valid, 0);
    check_eq("t6_stray_if", if_valid, 0);
    step();
    mem_rvalid = 0; step();

    // Randomized traffic against the model.
    do_reset();
    resp_pending = 0; resp_wait = 0; gnt_wait = 0;
    n_fetch_done = 0; n_data_done = 0;
    prev_if_valid = 0; prev_dm_valid = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (flush) begin
        if_req = 1'($urandom_range(0, 1));
        if_addr = 32'($urandom_range(0, 1023)) << 2;
      end else if (if_req && prev_if_valid) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 1023)) << 2;
      end else if (!if_req) begin
        if_req = ($urandom_range(0, 2) == 0);
        if_addr = 32'($urandom_range(0, 1023)) << 2;
      end
      flush = ($urandom_range(0, 15) == 0);
      if (dm_req && prev_dm_valid) begin
        dm_req = 0;
      end else if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1;
        dm_we = 1'($urandom_range(0, 1));
        dm_be = 4'($urandom_range(0, 15));
        dm_addr = 32'h8000 + (32'($urandom_range(0, 1023)) << 2);
        dm_wdata = $urandom;
      end
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (resp_pending) begin
        if (resp_wait == 0) begin
          mem_rvalid = 1; mem_rdata = hash(last_gnt_addr); resp_pending = 0;
        end else begin
          resp_wait--;
        end
      end else if (mem_req) begin
        if (gnt_wait >= 3 || $urandom_range(0, 1) == 1) begin
          mem_gnt = 1; gnt_wait = 0; resp_pending = 1;
          resp_wait = $urandom_range(0, 2);
        end else begin
          gnt_wait++;
        end
      end else begin
        gnt_wait = 0;
      end
      #1;
      if (if_valid && !flush) check_eq("rnd_if_data", if_rdata, hash(if_addr));
      if (dm_valid && !dm_we) check_eq("rnd_dm_data", dm_rdata, hash(dm_addr));
      step();
    end
    check_eq("rnd_fetches_seen", n_fetch_done > 0, 1);
    check_eq("rnd_data_seen", n_data_done > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
